// File: rtl/lsu_mem_sequencer_pkg.sv
// Shared load/store definitions: funct3 access codes, sequencer state encoding
// and the access legality rule used by the sequencer.
package lsu_mem_sequencer_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Exactly one of read/write, a known funct3, natural alignment; stores have no unsigned forms.
  function automatic logic ls_legal(input logic rd, input logic wr,
                                    input logic [2:0] t, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (t)
        LS_B:    ok = 1'b1;
        LS_BU:   ok = rd;
        LS_H:    ok = ~off[0];
        LS_HU:   ok = rd & ~off[0];
        LS_W:    ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_sequencer_if.sv
// Request/acknowledge data-memory bus between the load/store sequencer (master)
// and the data memory (slave).
interface lsu_mem_sequencer_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_sequencer_load_align.sv
// Combinational load extraction: selects the byte/half lane of a read word and
// sign- or zero-extends it according to the load funct3.
module lsu_mem_sequencer_load_align
  import lsu_mem_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_type,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_type)
      LS_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LS_BU:   o_data = {24'd0, w_byte};
      LS_H:    o_data = {{16{w_half[15]}}, w_half};
      LS_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Multi-cycle load/store sequencer: stalls the pipeline while a data-memory
// access is outstanding, builds store lanes/byte enables and returns extended load data.
module lsu_mem_sequencer
  import lsu_mem_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [2:0]          ls_type_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                stall_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic                rdata_valid_o,
  output logic                fault_o,
  output logic                timeout_o,
  lsu_mem_sequencer_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e      r_state;
  logic [2:0]      r_type;
  logic [1:0]      r_off;
  logic [CW-1:0]   r_cnt;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_rvalid;
  logic            r_timeout;

  logic            w_access;
  logic            w_legal;
  logic            w_accept;
  logic [XLEN-1:0] w_load_ext;

  function automatic logic [3:0] f_store_be(input logic [2:0] t, input logic [1:0] off);
    case (t)
      LS_B:    return 4'b0001 << off;
      LS_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_store_data(input logic [2:0] t, input logic [XLEN-1:0] w);
    case (t)
      LS_B:    return {4{w[7:0]}};
      LS_H:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  assign w_access = mem_read_i | mem_write_i;
  assign w_legal  = ls_legal(mem_read_i, mem_write_i, ls_type_i, addr_i[1:0]);
  assign w_accept = (r_state == ST_IDLE) & w_access & w_legal;

  // Accept and fault are decided in the same IDLE cycle the access is presented.
  assign stall_o = w_accept | (r_state == ST_REQ);
  assign fault_o = (r_state == ST_IDLE) & w_access & ~w_legal;

  lsu_mem_sequencer_load_align #(.XLEN(XLEN)) u_load_align (
    .i_word (dmem.dmem_rdata),
    .i_off  (r_off),
    .i_type (r_type),
    .o_data (w_load_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_type    <= 3'd0;
      r_off     <= 2'd0;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= 4'd0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_rvalid  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_type  <= ls_type_i;
            r_off   <= addr_i[1:0];
            r_we    <= mem_write_i;
            r_addr  <= {addr_i[XLEN-1:2], 2'b00};
            r_be    <= mem_write_i ? f_store_be(ls_type_i, addr_i[1:0]) : 4'hF;
            r_wdata <= mem_write_i ? f_store_data(ls_type_i, wdata_i) : '0;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack on the last watchdog cycle still completes the access.
          if (dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_DONE;
            if (!r_we) begin
              r_rdata  <= w_load_ext;
              r_rvalid <= 1'b1;
            end
          end else if ((r_cnt + 1'b1) == CW'(TIMEOUT_CYC)) begin
            r_cnt     <= r_cnt + 1'b1;
            r_req     <= 1'b0;
            r_rdata   <= '0;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdata_o         = r_rdata;
  assign rdata_valid_o   = r_rvalid;
  assign timeout_o       = r_timeout;
  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

endmodule
